// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM states and size helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Byte-lane data mask of an access of this size, right-justified.
    function automatic logic [63:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: load extract + sign/zero extend, and store byte-merge into a doubleword.
// Latency: combinational.
// Backpressure: none, pure datapath.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  lane,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [63:0] mem_dat,
    input  logic [63:0] st_dat,
    output logic [63:0] ld_dat,
    output logic [63:0] merged_dat
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] mask;

    always_comb begin
        shamt      = {lane, 3'b000};
        shifted    = mem_dat >> shamt;
        mask       = size_mask(size) << shamt;
        merged_dat = (mem_dat & ~mask) | ((st_dat << shamt) & mask);
        case (size)
            SZ_B:    ld_dat = {{56{is_signed & shifted[7]}},  shifted[7:0]};
            SZ_H:    ld_dat = {{48{is_signed & shifted[15]}}, shifted[15:0]};
            SZ_W:    ld_dat = {{32{is_signed & shifted[31]}}, shifted[31:0]};
            default: ld_dat = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator to a doubleword synchronous data memory (LSU_ALIGN_CHECK_EN enables misalignment faults).
// Latency accept->resp: fault 1, doubleword store 2, load 3, sub-word store 4 cycles.
// Backpressure: req_ready only in IDLE; requester holds req_valid until accepted.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [63:0] MEM_LIMIT = 64'h4000,
    parameter int          DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [63:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data
);

    state_e      state, state_nxt;
    logic        wr_q, signed_q, fault_q;
    size_e       size_q, size_in;
    logic [2:0]  lane_q;
    logic [63:0] eff_addr, align_mask;
    logic        bad;
    logic        accept;
    logic [63:0] ld_dat, merged_dat;

    always_comb begin
        size_in    = size_e'(req_size);
        align_mask = {60'd0, size_bytes(size_in) - 4'd1};
`ifdef LSU_ALIGN_CHECK_EN
        eff_addr   = req_addr;
        bad        = (req_addr >= MEM_LIMIT) || ((req_addr & align_mask) != 64'd0);
`else
        // Misaligned addresses are rounded down so no access straddles a doubleword.
        eff_addr   = req_addr & ~align_mask;
        bad        = (req_addr >= MEM_LIMIT);
`endif
    end

    assign accept = req_valid && (state == ST_IDLE);

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad)                               state_nxt = ST_RESP;
                    else if (req_write && size_in == SZ_D) state_nxt = ST_WR;
                    else                                   state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_read  = 1'b1;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: state_nxt = wr_q ? ST_WR : ST_RESP;
            ST_WR: begin
                mem_write = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign resp_fault = resp_valid & fault_q;

    lsu_lane_align u_lane_align (
        .lane       (lane_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .mem_dat    (mem_data),
        .st_dat     (mem_write_data),
        .ld_dat     (ld_dat),
        .merged_dat (merged_dat)
    );

    // mem_write_data holds the raw store data until the read-back merges into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wr_q           <= 1'b0;
            signed_q       <= 1'b0;
            fault_q        <= 1'b0;
            size_q         <= SZ_B;
            lane_q         <= 3'd0;
            mem_address    <= 64'd0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q           <= req_write;
                signed_q       <= req_signed;
                fault_q        <= bad;
                size_q         <= size_in;
                lane_q         <= eff_addr[2:0];
                mem_address    <= {eff_addr[63:3], 3'b000};
                mem_write_data <= req_wdata;
            end
            if (state == ST_RD_WAIT) begin
                if (wr_q) mem_write_data <= merged_dat;
                else      resp_rdata     <= ld_dat;
            end
        end
    end

endmodule
